nios_chave_debounce_ctrl: RTL and testbench



---
 rtl/nios_chave_debounce_ctrl_pkg.sv | 16 +
 rtl/nios_chave_debounce_bit.sv | 77 +++++++
 rtl/nios_chave_debounce_ctrl.sv | 104 ++++++++++
 tb/tb_nios_chave_debounce_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_chave_debounce_ctrl_pkg.sv
// Shared definitions for the switch (chave) debounce controller.
//   - Avalon word addresses of the register map.
//   - State encoding of the per-bit debounce FSM.
package nios_chave_debounce_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD     = 2'd2;
  localparam logic [1:0] ADDR_EDGE     = 2'd3;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/nios_chave_debounce_bit.sv
// Single-bit switch conditioner: 2-FF synchronizer, stability counter and debounce FSM.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous reset, active-high
//   in_bit in   raw asynchronous switch input
//   deb    out  debounced switch state
//   chg    out  one-cycle pulse, high in the cycle before deb takes its new value
module nios_chave_debounce_bit
  import nios_chave_debounce_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic deb,
  output logic chg
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  assign sync = sync_q[1];
  assign deb  = deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in_bit};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  // The first mismatched cycle already counts, so the new value is accepted after
  // exactly DEBOUNCE_CYCLES consecutive mismatched cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    chg     = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync != deb_q) begin
          state_d = ST_COUNTING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_COUNTING: begin
        if (sync == deb_q) begin
          // Glitch: input returned before qualifying.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          deb_d   = sync;
          chg     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/nios_chave_debounce_ctrl.sv
// Avalon-MM slave for the board switches: debounced DATA, IRQ_MASK, W1C EDGE_CAPTURE, irq.
// Build option: CHAVE_IRQ_EN -- when defined IRQ_MASK is implemented and irq is driven;
// otherwise IRQ_MASK reads 0, ignores writes, and irq is tied low (EDGE_CAPTURE remains
// usable for polling).
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active-high
//   address     in   Avalon word address (0 DATA, 1 IRQ_MASK, 2 reserved, 3 EDGE_CAPTURE)
//   chipselect  in   Avalon slave select
//   write       in   Avalon write strobe
//   writedata   in   Avalon write data
//   readdata    out  Avalon read data, registered, latency 1
//   in_port     in   raw asynchronous switch inputs
//   irq         out  level interrupt, active-high
module nios_chave_debounce_ctrl
  import nios_chave_debounce_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & write;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    nios_chave_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .in_bit(in_port[i]),
      .deb   (deb[i]),
      .chg   (chg[i])
    );
  end

`ifdef CHAVE_IRQ_EN
  logic [WIDTH-1:0] irq_mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
    end else if (wr_en && address == ADDR_IRQ_MASK) begin
      irq_mask_q <= writedata[WIDTH-1:0];
    end
  end

  assign irq_mask = irq_mask_q;
  // Decoded from flops only so the interrupt line cannot glitch.
  assign irq      = |(edge_q & irq_mask_q);
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  // A new change on the same clock as its clear wins, so no event is lost.
  always_comb begin
    w1c = '0;
    if (wr_en && address == ADDR_EDGE) begin
      w1c = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~w1c) | chg;
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = deb;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_RSVD:     rd_mux = '0;
      ADDR_EDGE:     rd_mux[WIDTH-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q   <= '0;
      readdata <= '0;
    end else begin
      edge_q   <= edge_d;
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nios_chave_debounce_ctrl.sv
// Self-checking bench for nios_chave_debounce_ctrl (WIDTH=4, DEBOUNCE_CYCLES=8).
// Expected values are queued when stimulus is applied and popped when the DUT output is sampled.
module tb_nios_chave_debounce_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DC    = 8;
`ifdef CHAVE_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_RSVD = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  logic             clk;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  nios_chave_debounce_ctrl #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 1'b1;
    in_port = '0;
    tick();
    tick();
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata: got %0h expected 0", readdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %0b expected 0", irq);
    end
    reset = 1'b0;
    address = A_DATA;
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e) begin
        errors++;
        $display("FAIL idle_data cycle %0d: got %0h expected %0h", k, readdata, e);
      end
    end
  endtask

  task automatic test_debounce_rise();
    logic [31:0] e, d;
    address = A_DATA;
    in_port[0] = 1'b1;
    // deb updates DC+2 edges after the step; readdata one edge later.
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back((k >= 11) ? 32'h1 : 32'h0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e) begin
        errors++;
        $display("FAIL rise_data edge %0d: got %0h expected %0h", k, readdata, e);
      end
    end
    exp_q.push_back(32'h1);
    rd(A_EDGE, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL rise_edge: got %0h expected %0h", d, e);
    end
    wr(A_DATA, 32'hF);
    exp_q.push_back(32'h1);
    rd(A_DATA, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL data_readonly: got %0h expected %0h", d, e);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] e, d;
    wr(A_EDGE, 32'hF);
    exp_q.push_back(32'h0);
    rd(A_EDGE, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL edge_cleared: got %0h expected %0h", d, e);
    end
    in_port[2] = 1'b1;
    repeat (5) tick();
    in_port[2] = 1'b0;
    repeat (20) tick();
    exp_q.push_back(32'h1);
    rd(A_DATA, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL glitch_data: got %0h expected %0h", d, e);
    end
    exp_q.push_back(32'h0);
    rd(A_EDGE, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL glitch_edge: got %0h expected %0h", d, e);
    end
    wr(A_RSVD, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    rd(A_RSVD, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL reserved: got %0h expected %0h", d, e);
    end
  endtask

  task automatic test_irq();
    logic [31:0] e, d;
    in_port[0] = 1'b0;
    repeat (12) tick();
    wr(A_EDGE, 32'hF);
    wr(A_MASK, 32'h1);
    exp_q.push_back(IrqEn ? 32'h1 : 32'h0);
    rd(A_MASK, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL mask_readback: got %0h expected %0h", d, e);
    end
    in_port[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back({31'h0, (k >= 10) && IrqEn});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (irq !== e[0]) begin
        errors++;
        $display("FAIL irq_rise edge %0d: got %0b expected %0b", k, irq, e[0]);
      end
    end
    wr(A_EDGE, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_cleared: got %0b expected 0", irq);
    end
    exp_q.push_back(32'h0);
    rd(A_EDGE, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL edge_w1c: got %0h expected %0h", d, e);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] e, d;
    wr(A_MASK, 32'h2);
    in_port[1] = 1'b1;
    repeat (9) tick();
    // chg on bit 1 is high during this write cycle.
    wr(A_EDGE, 32'h2);
    checks++;
    if (irq !== IrqEn) begin
      errors++;
      $display("FAIL set_wins_irq: got %0b expected %0b", irq, IrqEn);
    end
    exp_q.push_back(32'h2);
    rd(A_EDGE, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL set_wins_edge: got %0h expected %0h", d, e);
    end
    repeat (3) tick();
    checks++;
    if (irq !== IrqEn) begin
      errors++;
      $display("FAIL set_wins_irq_hold: got %0b expected %0b", irq, IrqEn);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] e, d;
    address = A_DATA;
    in_port[3] = 1'b1;
    repeat (7) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got rd=%0h irq=%0b expected rd=0 irq=0", readdata, irq);
    end
    tick();
    tick();
    reset = 1'b0;
    // Bits 0, 1 and 3 are high and re-qualify together from scratch.
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back((k >= 11) ? 32'hB : 32'h0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e) begin
        errors++;
        $display("FAIL requalify_data edge %0d: got %0h expected %0h", k, readdata, e);
      end
    end
    exp_q.push_back(32'hB);
    rd(A_EDGE, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL requalify_edge: got %0h expected %0h", d, e);
    end
    exp_q.push_back(32'h0);
    rd(A_MASK, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL mask_after_reset: got %0h expected %0h", d, e);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_reset: got %0b expected 0", irq);
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = A_DATA;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    in_port    = '0;
    test_reset();
    test_debounce_rise();
    test_glitch();
    test_irq();
    test_set_wins();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
